fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage.
- Owns the architectural fetch PC and drives the instruction bus request.
- Holds the request stable until `data_ok`, buffers a returned instruction while decode is stalled, and handles redirects from execute/commit.
- Redirects that arrive while a bus transaction is in flight discard the stale response, because the bus cannot cancel a request.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- PC_STEP, 4, PC increment per accepted instruction.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ireq_valid  out  1  instruction bus request valid
- ireq_addr  out  64  instruction bus request address
- iresp_data_ok  in  1  bus response valid this cycle
- iresp_data  in  32  bus response instruction
- stall_i  in  1  decode cannot accept this cycle
- redirect_valid  in  1  redirect request (branch/jump/exception)
- redirect_pc  in  64  redirect target
- out_valid  out  1  instruction presented to decode
- out_pc  out  64  PC of the presented instruction
- out_instr  out  32  presented instruction
- busy  out  1  fetch is waiting on the bus (stall source for the pipeline)

Behaviour:
- One clock domain: `clk`. Reset is asynchronous and active-low (`reset_n`).
- While `reset_n`=0:
  - state=IDLE, pc=RESET_PC, pend_pc=0, hold_instr=0.
  - All outputs are 0; `out_pc` is 0.
- States: IDLE, REQ, HOLD, DROP.
- IDLE: outputs idle; next cycle goes to REQ. Exists only to keep `ireq_valid` low for the first cycle after reset release.
- REQ:
  - `ireq_valid`=1, `ireq_addr`=pc, `busy`=~iresp_data_ok.
  - Address and valid stay stable until `data_ok`.
  - `data_ok` & ~redirect & ~stall_i: `out_valid`=1 combinationally, with `out_instr`=iresp_data and `out_pc`=pc. Then pc<=pc+PC_STEP and stay in REQ. Zero-bubble back-to-back fetch.
  - `data_ok` & ~redirect & stall_i: `out_valid`=1 this cycle but not accepted. hold_instr<=iresp_data, go to HOLD.
  - `data_ok` & redirect: response discarded, `out_valid`=0. pc<=redirect_pc, stay in REQ.
  - ~data_ok & redirect: pend_pc<=redirect_pc, go to DROP. `ireq_addr` stays at the old pc.
  - ~data_ok & ~redirect: stay in REQ.
- HOLD:
  - `ireq_valid`=0, `busy`=0, `out_valid`=1, `out_instr`=hold_instr, `out_pc`=pc.
  - ~stall_i & ~redirect: pc<=pc+PC_STEP, go to REQ.
  - redirect, with any `stall_i`: held instruction dropped. pc<=redirect_pc, go to REQ.
- DROP:
  - `ireq_valid`=1, `ireq_addr`=old pc, `out_valid`=0, `busy`=1.
  - redirect: pend_pc<=redirect_pc; the latest redirect wins.
  - `data_ok`: response discarded. pc<=(redirect ? redirect_pc : pend_pc), go to REQ.
- Redirect has priority over every other event in every state except IDLE. In IDLE a redirect is ignored.
- PC arithmetic is modulo 2^64; pc=64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- `redirect_pc[1:0]` is used as given (no alignment masking).
- `iresp_data_ok` in IDLE or HOLD is a protocol error and is ignored.
- Outputs not specified for a state are 0.
- Reset asserted mid-transaction returns to IDLE immediately. Any in-flight response is ignored because `ireq_valid` is 0.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- Defined:
  - Adds outputs `perf_wait_cnt` (64) and `perf_drop_cnt` (64).
  - `perf_wait_cnt` increments every cycle `busy`=1.
  - `perf_drop_cnt` increments once per discarded response (REQ redirect+data_ok, or DROP data_ok).
  - Both reset to 0 and saturate at all-ones.
- Undefined: no ports and no logic for these counters; all other behaviour is identical.

Test Plan:
- Reset release, `data_ok` returned 2 cycles after each request, stall_i=0 -> first `ireq_addr`=0x80000000 one cycle after reset release. `out_valid` pulses with `out_pc` 0x80000000, then 0x80000004, 0x80000008.
- `data_ok` every cycle, stall_i=1 for 3 cycles at PC 0x80000004 -> HOLD with `ireq_valid`=0. `out_instr` is stable for 3 cycles; after stall release the next request addr is 0x80000008.
- Redirect to 0x80001000 while waiting at 0x80000008, `data_ok` arrives 3 cycles later -> `ireq_addr` stays 0x80000008 until `data_ok`, that response is not presented, and the next request is 0x80001000.
- Two redirects in DROP (0x2000, then 0x3000), then `data_ok` -> next fetch is 0x3000. Redirect coincident with `data_ok` in REQ -> response dropped, next fetch is the redirect target.
- Redirect during HOLD with stall_i=1 -> held instruction dropped, REQ to the target. reset_n low mid-DROP -> all outputs 0 asynchronously, and after release the fetch restarts at RESET_PC.
- With FETCH_CTRL_PERF_EN: the scenario-3 sequence gives `perf_drop_cnt`=1 and `perf_wait_cnt` equal to the counted busy cycles.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the instruction bus and
// buffers/discards responses around decode stalls and redirects. Optional macro: FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        busy
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [63:0] perf_wait_cnt,
    output logic [63:0] perf_drop_cnt
`endif
);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_REQ  = 2'd1;
    localparam logic [1:0]  ST_HOLD = 2'd2;
    localparam logic [1:0]  ST_DROP = 2'd3;
    localparam logic [63:0] PC_INC  = 64'(PC_STEP);

    logic [1:0]  state_r, state_s;
    logic [63:0] pc_r, pc_s;
    logic [63:0] pend_pc_r, pend_pc_s;
    logic [31:0] hold_instr_r, hold_instr_s;
    logic        drop_s;

    // Next-state and output decode; redirect outranks every other event outside IDLE.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        pend_pc_s    = pend_pc_r;
        hold_instr_s = hold_instr_r;
        drop_s       = 1'b0;
        ireq_valid   = 1'b0;
        ireq_addr    = 64'd0;
        out_valid    = 1'b0;
        out_pc       = 64'd0;
        out_instr    = 32'd0;
        busy         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_REQ;
            end
            ST_REQ: begin
                ireq_valid = 1'b1;
                ireq_addr  = pc_r;
                busy       = ~iresp_data_ok;
                if (redirect_valid) begin
                    if (iresp_data_ok) begin
                        pc_s   = redirect_pc;
                        drop_s = 1'b1;
                    end else begin
                        // The bus cannot cancel, so wait out the stale response in DROP.
                        pend_pc_s = redirect_pc;
                        state_s   = ST_DROP;
                    end
                end else if (iresp_data_ok) begin
                    out_valid = 1'b1;
                    out_pc    = pc_r;
                    out_instr = iresp_data;
                    if (stall_i) begin
                        hold_instr_s = iresp_data;
                        state_s      = ST_HOLD;
                    end else begin
                        pc_s = pc_r + PC_INC;
                    end
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                out_pc    = pc_r;
                out_instr = hold_instr_r;
                if (redirect_valid) begin
                    pc_s    = redirect_pc;
                    state_s = ST_REQ;
                end else if (!stall_i) begin
                    pc_s    = pc_r + PC_INC;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                ireq_valid = 1'b1;
                ireq_addr  = pc_r;
                busy       = 1'b1;
                if (iresp_data_ok) begin
                    drop_s  = 1'b1;
                    pc_s    = redirect_valid ? redirect_pc : pend_pc_r;
                    state_s = ST_REQ;
                end else if (redirect_valid) begin
                    pend_pc_s = redirect_pc;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Architectural fetch state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            pend_pc_r    <= 64'd0;
            hold_instr_r <= 32'd0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            pend_pc_r    <= pend_pc_s;
            hold_instr_r <= hold_instr_s;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (v == 64'hFFFF_FFFF_FFFF_FFFF) ? v : v + 64'd1;
    endfunction

    logic [63:0] perf_wait_r;
    logic [63:0] perf_drop_r;

    // Saturating counters for bus wait cycles and discarded responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_wait_r <= 64'd0;
            perf_drop_r <= 64'd0;
        end else begin
            if (busy) begin
                perf_wait_r <= sat_inc(perf_wait_r);
            end else begin
                perf_wait_r <= perf_wait_r;
            end
            if (drop_s) begin
                perf_drop_r <= sat_inc(perf_drop_r);
            end else begin
                perf_drop_r <= perf_drop_r;
            end
        end
    end

    assign perf_wait_cnt = perf_wait_r;
    assign perf_drop_cnt = perf_drop_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
`endif

endmodule
